// File: rtl/snake_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl_if
// Purpose : bundles the keyboard, food, renderer-query and status signals that
//           connect the snake controller to the PS/2 decoder and VGA draw logic.
// Signals : newKeyStrobe/keycode  - one-cycle key event with set-2 make code
//           grow                  - food eaten pulse
//           query_x/query_y       - renderer cell coordinates
//           query_hit/query_head  - occupancy answer (1 cycle later)
//           state/head_x/head_y/snake_len/snake_dir/step - game status
// Modports: master drives keys/food/query (decoder + renderer side),
//           slave is the controller.
// -----------------------------------------------------------------------------
interface snake_game_ctrl_if #(
  parameter int XW = 6,
  parameter int YW = 6,
  parameter int LW = 5
);
  logic          newKeyStrobe;
  logic [7:0]    keycode;
  logic          grow;
  logic [XW-1:0] query_x;
  logic [YW-1:0] query_y;
  logic          query_hit;
  logic          query_head;
  logic [1:0]    state;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] snake_len;
  logic [1:0]    snake_dir;
  logic          step;

  modport master (
    output newKeyStrobe, keycode, grow, query_x, query_y,
    input  query_hit, query_head, state, head_x, head_y, snake_len, snake_dir, step
  );

  modport slave (
    input  newKeyStrobe, keycode, grow, query_x, query_y,
    output query_hit, query_head, state, head_x, head_y, snake_len, snake_dir, step
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
// Purpose : game-state machine (Paused/Play/GameOver/BlackOut) and snake motion
//           for the VGA snake game. Moves the snake one cell every TICK_DIV
//           cycles while playing, detects wall/self collision, handles growth
//           and answers per-cell occupancy queries for the renderer.
// Ports   : clk100MHz - system clock
//           reset     - asynchronous, active-high
//           bus       - snake_game_ctrl_if.slave (keys, grow, query, status)
// -----------------------------------------------------------------------------
module snake_game_ctrl #(
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 4,
  parameter int TICK_DIV  = 2000000,
  parameter int START_X   = 31,
  parameter int START_Y   = 23,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             clk100MHz,
  input  logic             reset,
  snake_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_PLAY   = 2'd1,
    ST_OVER   = 2'd2,
    ST_BLACK  = 2'd3
  } state_t;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  state_t        r_state;
  logic [1:0]    r_dir;
  logic [1:0]    r_next_dir;
  logic          r_grow_pend;
  logic [TW-1:0] r_tick;
  logic [LW-1:0] r_len;
  logic          r_step;
  logic          r_qhit;
  logic          r_qhead;
  // Segment 0 is the head; segment i sits i moves behind it.
  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];

  logic          w_key_s, w_key_p, w_key_r, w_key_esc;
  logic          w_arrow_vld;
  logic [1:0]    w_arrow_dir;
  logic          w_tick_wrap;
  logic          w_do_step;
  logic          w_grow_eff;
  logic          w_len_inc;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_wall;
  logic          w_self;
  logic          w_qhit;
  logic          w_qhead;

  // Initial layout: a horizontal line extending west from the start cell.
  function automatic logic [XW-1:0] init_x(input int i);
    init_x = (i < START_LEN) ? XW'(START_X - i) : XW'(0);
  endfunction

  function automatic logic [YW-1:0] init_y(input int i);
    init_y = (i < START_LEN) ? YW'(START_Y) : YW'(0);
  endfunction

  assign w_key_s   = bus.newKeyStrobe && (bus.keycode == 8'h1B);
  assign w_key_p   = bus.newKeyStrobe && (bus.keycode == 8'h4D);
  assign w_key_r   = bus.newKeyStrobe && (bus.keycode == 8'h2D);
  assign w_key_esc = bus.newKeyStrobe && (bus.keycode == 8'h76);

  assign w_tick_wrap = (r_state == ST_PLAY) && (r_tick == TW'(TICK_DIV - 1));
  // A state-changing key (S, P, ESC) takes the cycle: no move on that tick.
  assign w_do_step   = w_tick_wrap && !w_key_s && !w_key_p && !w_key_esc;
  // A grow arriving together with the tick already counts for that step.
  assign w_grow_eff  = r_grow_pend || (bus.grow && (r_state == ST_PLAY));
  assign w_len_inc   = w_grow_eff && (r_len < LW'(MAX_LEN));

  // Arrow key decode.
  always_comb begin
    w_arrow_vld = 1'b0;
    w_arrow_dir = DIR_N;
    if (bus.newKeyStrobe) begin
      case (bus.keycode)
        8'h75:   begin w_arrow_vld = 1'b1; w_arrow_dir = DIR_N; end
        8'h74:   begin w_arrow_vld = 1'b1; w_arrow_dir = DIR_E; end
        8'h72:   begin w_arrow_vld = 1'b1; w_arrow_dir = DIR_S; end
        8'h6B:   begin w_arrow_vld = 1'b1; w_arrow_dir = DIR_W; end
        default: begin w_arrow_vld = 1'b0; w_arrow_dir = DIR_N; end
      endcase
    end else begin
      w_arrow_vld = 1'b0;
    end
  end

  // Candidate head for the next step and wall detection on the move axis.
  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_wall = 1'b0;
    case (r_next_dir)
      DIR_N: begin w_wall = (r_seg_y[0] == YW'(0));          w_ny = r_seg_y[0] - YW'(1); end
      DIR_E: begin w_wall = (r_seg_x[0] == XW'(GRID_W - 1)); w_nx = r_seg_x[0] + XW'(1); end
      DIR_S: begin w_wall = (r_seg_y[0] == YW'(GRID_H - 1)); w_ny = r_seg_y[0] + YW'(1); end
      DIR_W: begin w_wall = (r_seg_x[0] == XW'(0));          w_nx = r_seg_x[0] - XW'(1); end
      default: w_wall = 1'b0;
    endcase
  end

  // Self collision: the tail is exempt when it will vacate (no grow pending).
  always_comb begin
    w_self = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny) &&
          !((LW'(i) == r_len - LW'(1)) && !w_grow_eff)) begin
        w_self = 1'b1;
      end else begin
        w_self = w_self;
      end
    end
  end

  // Parallel occupancy compare for the renderer query.
  always_comb begin
    w_qhit  = 1'b0;
    w_qhead = (r_seg_x[0] == bus.query_x) && (r_seg_y[0] == bus.query_y);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_seg_x[i] == bus.query_x) && (r_seg_y[i] == bus.query_y)) begin
        w_qhit = 1'b1;
      end else begin
        w_qhit = w_qhit;
      end
    end
  end

  // Game FSM, tick divider, direction latch and segment shift register.
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_state     <= ST_PAUSED;
      r_dir       <= DIR_E;
      r_next_dir  <= DIR_E;
      r_grow_pend <= 1'b0;
      r_tick      <= '0;
      r_len       <= LW'(START_LEN);
      r_step      <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= init_y(i);
      end
    end else begin
      r_step <= 1'b0;
      if (w_key_s) begin
        r_state     <= ST_PLAY;
        r_dir       <= DIR_E;
        r_next_dir  <= DIR_E;
        r_grow_pend <= 1'b0;
        r_tick      <= '0;
        r_len       <= LW'(START_LEN);
        for (int i = 0; i < MAX_LEN; i++) begin
          r_seg_x[i] <= init_x(i);
          r_seg_y[i] <= init_y(i);
        end
      end else begin
        case (r_state)
          ST_PLAY: begin
            r_tick <= w_tick_wrap ? TW'(0) : r_tick + TW'(1);
            // Reversal is judged against the committed direction.
            if (w_arrow_vld && (w_arrow_dir != (r_dir ^ 2'd2))) begin
              r_next_dir <= w_arrow_dir;
            end
            if (w_do_step) begin
              if (w_wall || w_self) begin
                r_state <= ST_OVER;
              end else begin
                r_dir <= r_next_dir;
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                  r_seg_x[i] <= r_seg_x[i-1];
                  r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0]  <= w_nx;
                r_seg_y[0]  <= w_ny;
                r_len       <= w_len_inc ? r_len + LW'(1) : r_len;
                r_step      <= 1'b1;
                r_grow_pend <= 1'b0;
              end
            end else begin
              if (bus.grow) begin
                r_grow_pend <= 1'b1;
              end
              if (w_key_p) begin
                r_state <= ST_PAUSED;
              end else if (w_key_esc) begin
                r_state <= ST_BLACK;
              end
            end
          end
          ST_PAUSED: begin
            if (w_key_p || w_key_r) begin
              r_state <= ST_PLAY;
            end else if (w_key_esc) begin
              r_state <= ST_BLACK;
            end
          end
          ST_OVER: begin
            if (w_key_esc) begin
              r_state <= ST_BLACK;
            end
          end
          ST_BLACK: begin
            r_state <= ST_BLACK;
          end
          default: r_state <= ST_PAUSED;
        endcase
      end
    end
  end

  // Registered query answer, blanked while the display is blacked out.
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_qhit  <= 1'b0;
      r_qhead <= 1'b0;
    end else begin
      r_qhit  <= (r_state != ST_BLACK) && w_qhit;
      r_qhead <= (r_state != ST_BLACK) && w_qhead;
    end
  end

  assign bus.query_hit  = r_qhit;
  assign bus.query_head = r_qhead;
  assign bus.state      = r_state;
  assign bus.head_x     = r_seg_x[0];
  assign bus.head_y     = r_seg_y[0];
  assign bus.snake_len  = r_len;
  assign bus.snake_dir  = r_dir;
  assign bus.step       = r_step;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_game_ctrl
// Directed scenarios plus randomized key/grow/query traffic, checked every
// cycle against a queue-based model of the snake game rules.
// -----------------------------------------------------------------------------
module tb_snake_game_ctrl;
  localparam int GW = 64, GH = 48, ML = 6, SL = 4, TD = 4, SX = 31, SY = 23;
  localparam int XW = 6, YW = 6, LW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_game_ctrl_if #(.XW(XW), .YW(YW), .LW(LW)) bus();

  snake_game_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .START_LEN(SL),
    .TICK_DIV(TD), .START_X(SX), .START_Y(SY)
  ) dut (
    .clk100MHz(clk),
    .reset(rst),
    .bus(bus)
  );

  // Model: state, committed/next direction, pending grow, tick, snake as queues.
  int m_state, m_dir, m_next, m_pend, m_tick, m_step, m_qhit, m_qhead;
  int sx[$];
  int sy[$];

  int  n_checks = 0;
  int  n_err    = 0;
  bit  cmp_en   = 1'b0;
  bit  q_fix    = 1'b0;
  int  q_fx, q_fy;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    sx.delete();
    sy.delete();
    for (int i = 0; i < SL; i++) begin
      sx.push_back(SX - i);
      sy.push_back(SY);
    end
    m_dir  = 1;
    m_next = 1;
    m_pend = 0;
  endtask

  task automatic model_reset();
    model_init();
    m_state = 0;
    m_tick  = 0;
    m_step  = 0;
    m_qhit  = 0;
    m_qhead = 0;
  endtask

  function automatic int arrow_dir(input int kc);
    case (kc)
      8'h75:   return 0;
      8'h74:   return 1;
      8'h72:   return 2;
      8'h6B:   return 3;
      default: return -1;
    endcase
  endfunction

  // One clock edge of the game rules.
  task automatic model_step(input bit kv, input int kc, input bit g, input int qx, input int qy);
    bit is_s, is_p, is_r, is_e, wrap, ge, die;
    int ad, newnext, nx, ny;
    m_qhit  = 0;
    m_qhead = 0;
    if (m_state != 3) begin
      foreach (sx[i]) if (sx[i] == qx && sy[i] == qy) m_qhit = 1;
      if (sx[0] == qx && sy[0] == qy) m_qhead = 1;
    end
    m_step = 0;
    is_s = kv && kc == 8'h1B;
    is_p = kv && kc == 8'h4D;
    is_r = kv && kc == 8'h2D;
    is_e = kv && kc == 8'h76;
    if (is_s) begin
      model_init();
      m_state = 1;
      m_tick  = 0;
      return;
    end
    case (m_state)
      1: begin
        wrap   = (m_tick == TD - 1);
        m_tick = wrap ? 0 : m_tick + 1;
        ge     = m_pend || g;
        ad     = kv ? arrow_dir(kc) : -1;
        newnext = (ad >= 0 && ad != (m_dir + 2) % 4) ? ad : m_next;
        if (wrap && !is_p && !is_e) begin
          nx = sx[0];
          ny = sy[0];
          case (m_next)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
          endcase
          die = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
          for (int i = 0; i < sx.size(); i++) begin
            if (!(i == sx.size() - 1 && !ge) && sx[i] == nx && sy[i] == ny) die = 1;
          end
          if (die) begin
            m_state = 2;
          end else begin
            m_dir = m_next;
            sx.push_front(nx);
            sy.push_front(ny);
            if (!(ge && sx.size() <= ML)) begin
              void'(sx.pop_back());
              void'(sy.pop_back());
            end
            m_step = 1;
            m_pend = 0;
          end
        end else begin
          if (g) m_pend = 1;
          if (is_p) m_state = 0;
          else if (is_e) m_state = 3;
        end
        m_next = newnext;
      end
      0: begin
        if (is_p || is_r) m_state = 1;
        else if (is_e) m_state = 3;
      end
      2: if (is_e) m_state = 3;
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle at negedge.
  task automatic cycle(input bit kv, input logic [7:0] kc, input bit g);
    int qx, qy, k;
    if (q_fix) begin
      qx = q_fx;
      qy = q_fy;
    end else if ($urandom_range(0, 1) == 0) begin
      k  = $urandom_range(0, sx.size() - 1);
      qx = sx[k];
      qy = sy[k];
    end else begin
      qx = $urandom_range(0, GW - 1);
      qy = $urandom_range(0, GH - 1);
    end
    bus.newKeyStrobe = kv;
    bus.keycode      = kc;
    bus.grow         = g;
    bus.query_x      = qx[XW-1:0];
    bus.query_y      = qy[YW-1:0];
    @(posedge clk);
    model_step(kv, int'(kc), g, qx, qy);
    @(negedge clk);
  endtask

  // Run at least one cycle, then until a step pulse or the budget runs out.
  task automatic wait_step(input string name);
    int k = 0;
    do begin
      cycle(1'b0, 8'h00, 1'b0);
      k++;
    end while (bus.step !== 1'b1 && k < 4 * TD);
    n_checks++;
    if (bus.step !== 1'b1) begin
      n_err++;
      $display("FAIL %s: no step pulse within %0d cycles (got step=%0b, expected 1)", name, k, bus.step);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state",      int'(bus.state),      m_state);
      chk("head_x",     int'(bus.head_x),     sx[0]);
      chk("head_y",     int'(bus.head_y),     sy[0]);
      chk("snake_len",  int'(bus.snake_len),  sx.size());
      chk("snake_dir",  int'(bus.snake_dir),  m_dir);
      chk("step",       int'(bus.step),       m_step);
      chk("query_hit",  int'(bus.query_hit),  m_qhit);
      chk("query_head", int'(bus.query_head), m_qhead);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int nsteps, k, r, hx, guard;
    logic [7:0] kc;
    bit kv, g;
    rst = 1'b1;
    bus.newKeyStrobe = 1'b0;
    bus.keycode = 8'h00;
    bus.grow = 1'b0;
    bus.query_x = '0;
    bus.query_y = '0;
    model_reset();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_head_x", int'(bus.head_x), 31);
    chk("rst_head_y", int'(bus.head_y), 23);
    chk("rst_len", int'(bus.snake_len), 4);
    chk("rst_dir", int'(bus.snake_dir), 1);
    chk("rst_qhit", int'(bus.query_hit), 0);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);

    // Start and four steps east.
    cycle(1'b1, 8'h1B, 1'b0);
    chk("start_state", int'(bus.state), 1);
    chk("start_head_x", int'(bus.head_x), 31);
    chk("start_len", int'(bus.snake_len), 4);
    nsteps = 0;
    repeat (4 * TD) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (bus.step) nsteps++;
    end
    chk("four_steps", nsteps, 4);
    chk("run_head_x", int'(bus.head_x), 35);
    chk("run_head_y", int'(bus.head_y), 23);

    // Reversal ignored; last valid arrow before the step wins.
    cycle(1'b1, 8'h6B, 1'b0);
    wait_step("rev_step");
    chk("rev_dir", int'(bus.snake_dir), 1);
    chk("rev_head_x", int'(bus.head_x), 36);
    cycle(1'b1, 8'h75, 1'b0);
    cycle(1'b1, 8'h74, 1'b0);
    wait_step("last_arrow_step");
    chk("last_arrow_dir", int'(bus.snake_dir), 1);
    chk("last_arrow_x", int'(bus.head_x), 37);
    chk("last_arrow_y", int'(bus.head_y), 23);

    // East wall.
    guard = 0;
    while (bus.head_x != 6'd62 && guard < 40) begin
      wait_step("wall_approach");
      guard++;
    end
    wait_step("wall_edge_step");
    chk("wall_edge_x", int'(bus.head_x), 63);
    chk("wall_edge_state", int'(bus.state), 1);
    nsteps = 0;
    repeat (TD) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (bus.step) nsteps++;
    end
    chk("wall_state", int'(bus.state), 2);
    chk("wall_frozen_x", int'(bus.head_x), 63);
    chk("wall_no_step", nsteps, 0);

    // Growth saturating at MAX_LEN, then tail query.
    cycle(1'b1, 8'h1B, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    wait_step("grow1");
    chk("grow1_len", int'(bus.snake_len), 5);
    cycle(1'b0, 8'h00, 1'b1);
    wait_step("grow2");
    chk("grow2_len", int'(bus.snake_len), 6);
    cycle(1'b0, 8'h00, 1'b1);
    wait_step("grow3");
    chk("grow3_len", int'(bus.snake_len), 6);
    chk("grow3_head_x", int'(bus.head_x), 34);
    q_fix = 1'b1; q_fx = 29; q_fy = 23;
    cycle(1'b0, 8'h00, 1'b0);
    chk("tail_qhit", int'(bus.query_hit), 1);
    chk("tail_qhead", int'(bus.query_head), 0);
    q_fx = 28;
    cycle(1'b0, 8'h00, 1'b0);
    chk("past_tail_qhit", int'(bus.query_hit), 0);
    q_fx = 34;
    cycle(1'b0, 8'h00, 1'b0);
    chk("head_qhead", int'(bus.query_head), 1);
    q_fix = 1'b0;

    // Length-5 loop bites its own body.
    cycle(1'b1, 8'h1B, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    wait_step("loop5_s1");
    cycle(1'b1, 8'h75, 1'b0);
    wait_step("loop5_s2");
    cycle(1'b1, 8'h6B, 1'b0);
    wait_step("loop5_s3");
    chk("loop5_head_x", int'(bus.head_x), 31);
    chk("loop5_head_y", int'(bus.head_y), 22);
    cycle(1'b1, 8'h72, 1'b0);
    repeat (TD) cycle(1'b0, 8'h00, 1'b0);
    chk("loop5_state", int'(bus.state), 2);

    // Length-4 loop into the vacating tail survives.
    cycle(1'b1, 8'h1B, 1'b0);
    cycle(1'b1, 8'h75, 1'b0);
    wait_step("loop4_s1");
    cycle(1'b1, 8'h6B, 1'b0);
    wait_step("loop4_s2");
    cycle(1'b1, 8'h72, 1'b0);
    wait_step("loop4_s3");
    chk("loop4_state", int'(bus.state), 1);
    chk("loop4_head_x", int'(bus.head_x), 30);
    chk("loop4_head_y", int'(bus.head_y), 23);

    // Pause holds the counter; resume finishes the remaining count.
    wait_step("pause_sync");
    cycle(1'b1, 8'h4D, 1'b0);
    chk("pause_state", int'(bus.state), 0);
    hx = int'(bus.head_y);
    nsteps = 0;
    repeat (10) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (bus.step) nsteps++;
    end
    chk("pause_no_step", nsteps, 0);
    chk("pause_hold_y", int'(bus.head_y), hx);
    cycle(1'b1, 8'h4D, 1'b0);
    chk("resume_state", int'(bus.state), 1);
    k = 0;
    while (!bus.step && k < 10) begin
      cycle(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("resume_latency", k, 3);

    // BlackOut blanks queries and ignores P/R.
    cycle(1'b1, 8'h76, 1'b0);
    chk("esc_state", int'(bus.state), 3);
    q_fix = 1'b1; q_fx = sx[0]; q_fy = sy[0];
    cycle(1'b0, 8'h00, 1'b0);
    chk("black_qhit", int'(bus.query_hit), 0);
    chk("black_qhead", int'(bus.query_head), 0);
    q_fix = 1'b0;
    cycle(1'b1, 8'h4D, 1'b0);
    chk("black_p", int'(bus.state), 3);
    cycle(1'b1, 8'h2D, 1'b0);
    chk("black_r", int'(bus.state), 3);
    cycle(1'b1, 8'h1B, 1'b0);
    chk("black_s_state", int'(bus.state), 1);
    chk("black_s_head_x", int'(bus.head_x), 31);

    // Asynchronous reset mid-play.
    repeat (6) cycle(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(bus.state), 0);
    chk("arst_head_x", int'(bus.head_x), 31);
    chk("arst_len", int'(bus.snake_len), 4);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    cycle(1'b1, 8'h1B, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      kv = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 19);
      case (r)
        0: kc = 8'h1B;
        1: kc = 8'h4D;
        2: kc = 8'h2D;
        3: kc = 8'h76;
        4: kc = 8'h1C;
        5, 6, 7: kc = 8'h75;
        8, 9, 10: kc = 8'h72;
        11, 12, 13: kc = 8'h6B;
        default: kc = 8'h74;
      endcase
      g = ($urandom_range(0, 7) == 0);
      cycle(kv, kc, g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
